// File: rtl/shift_arbiter_if.sv
// ============================================================================
// Module   : shift_arbiter_if
// Brief    : Request/response bundle for shift_arbiter (two requesters, one
//            tagged response channel, completed-operation count).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface shift_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter int CNTW  = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [SHW-1:0]   req0_b;
    logic             req0_sel;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [SHW-1:0]   req1_b;
    logic             req1_sel;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_out;
    logic             rsp_of;
    logic [CNTW-1:0]  op_count;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sel,
        output req1_valid, req1_a, req1_b, req1_sel,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_out, rsp_of, op_count
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel,
        input  req1_valid, req1_a, req1_b, req1_sel,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_out, rsp_of, op_count
    );
endinterface

`default_nettype wire

// File: rtl/shift_arbiter.sv
// ============================================================================
// Module   : shift_arbiter (with signed_shift)
// Brief    : Round-robin arbiter sharing one signed shifter between two
//            requesters. Optional macro SHIFT_ARB_SAT_EN saturates overflowing
//            left shifts.
// Revision : 1.0
// ============================================================================
`default_nettype none

module signed_shift #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  wire logic [WIDTH-1:0] a_i,
    input  wire logic [SHW-1:0]   b_i,
    input  wire logic             sel_i,
    output logic      [WIDTH-1:0] out_o,
    output logic                  of_o
);
    logic signed [WIDTH-1:0] shl_w;
    logic signed [WIDTH-1:0] back_w;
    logic signed [WIDTH-1:0] shr_w;

    // A left shift is representable exactly when shifting back recovers a.
    always_comb begin
        shl_w  = $signed(a_i) <<< b_i;
        back_w = shl_w >>> b_i;
        shr_w  = $signed(a_i) >>> b_i;
        if (sel_i) begin
            out_o = shl_w;
            of_o  = (back_w != $signed(a_i));
        end else begin
            out_o = shr_w;
            of_o  = 1'b0;
        end
    end
endmodule

module shift_arbiter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter int CNTW  = 16
) (
    input  wire logic      clk,
    input  wire logic      rst,
    shift_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic             last_q;
    logic [WIDTH-1:0] a_q;
    logic [SHW-1:0]   b_q;
    logic             sel_q;
    logic             id_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_out_q;
    logic             rsp_of_q;
    logic [CNTW-1:0]  op_count_q;

    logic             any_w;
    logic             grant_w;
    logic             accept_w;
    logic [WIDTH-1:0] sh_out_w;
    logic             sh_of_w;
    logic [WIDTH-1:0] cap_out_w;

    // With both pending, the requester not served last wins.
    always_comb begin
        any_w = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_w = ~last_q;
        end else begin
            grant_w = bus.req1_valid;
        end
        accept_w = (state_q == IDLE) && any_w;
    end

    assign bus.req0_ready = (state_q == IDLE) && bus.req0_valid && !grant_w;
    assign bus.req1_ready = (state_q == IDLE) && bus.req1_valid &&  grant_w;

    signed_shift #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shift (
        .a_i   (a_q),
        .b_i   (b_q),
        .sel_i (sel_q),
        .out_o (sh_out_w),
        .of_o  (sh_of_w)
    );

`ifdef SHIFT_ARB_SAT_EN
    localparam logic [WIDTH-1:0] c_sat_pos = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_sat_neg = {1'b1, {(WIDTH-1){1'b0}}};

    // Overflow is only ever flagged on left shifts, so right shifts pass through.
    always_comb begin
        if (sh_of_w) begin
            cap_out_w = a_q[WIDTH-1] ? c_sat_neg : c_sat_pos;
        end else begin
            cap_out_w = sh_out_w;
        end
    end
`else
    assign cap_out_w = sh_out_w;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= 1'b0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_out_q   <= '0;
            rsp_of_q    <= 1'b0;
            op_count_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_w) begin
                        a_q     <= grant_w ? bus.req1_a   : bus.req0_a;
                        b_q     <= grant_w ? bus.req1_b   : bus.req0_b;
                        sel_q   <= grant_w ? bus.req1_sel : bus.req0_sel;
                        id_q    <= grant_w;
                        last_q  <= grant_w;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_out_q   <= cap_out_w;
                    rsp_of_q    <= sh_of_w;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + {{(CNTW-1){1'b0}}, 1'b1};
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_out   = rsp_out_q;
    assign bus.rsp_of    = rsp_of_q;
    assign bus.op_count  = op_count_q;
endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter.sv
// ============================================================================
// Module   : tb_shift_arbiter
// Brief    : Self-checking bench for shift_arbiter with an expected-response queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_shift_arbiter;
    localparam int WIDTH = 32;
    localparam int SHW   = 5;
    localparam int CNTW  = 16;
    localparam int TMO   = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shift_arbiter_if #(.WIDTH(WIDTH), .SHW(SHW), .CNTW(CNTW)) bus ();

    shift_arbiter #(.WIDTH(WIDTH), .SHW(SHW), .CNTW(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        id;
        logic [31:0] out;
        logic        of;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic exp_t model(input logic id, input logic [31:0] a,
                                   input logic [4:0] b, input logic sel);
        exp_t   e;
        longint w;
        e.id = id;
        if (sel) begin
            w     = longint'($signed(a)) <<< b;
            e.out = w[31:0];
            e.of  = (w != longint'($signed(w[31:0])));
`ifdef SHIFT_ARB_SAT_EN
            if (e.of) e.out = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        end else begin
            e.out = 32'($signed(a) >>> b);
            e.of  = 1'b0;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic [31:0] a,
                           input logic [4:0] b, input logic s);
        if (k == 0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_sel = s;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_sel = s;
        end
    endtask

    // Raise valid, wait for ready, log the expected response, then drop valid.
    task automatic issue(input int k, input logic [31:0] a, input logic [4:0] b,
                         input logic s, output int waited);
        set_req(k, 1'b1, a, b, s);
        #1;
        waited = 0;
        while (!((k == 0) ? bus.req0_ready : bus.req1_ready) && waited < TMO) begin
            tick();
            waited++;
        end
        if (waited < TMO) sb.push_back(model(k[0], a, b, s));
        tick();
        set_req(k, 1'b0, a, b, s);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.rsp_valid && n < TMO) begin
            tick();
            n++;
        end
    endtask

    task automatic handshake();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_req(0, 1'b0, '0, '0, 1'b0);
        set_req(1, 1'b0, '0, '0, 1'b0);
        bus.rsp_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_of} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=00000",
                     {bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_of});
        end
        checks++;
        if (bus.rsp_out !== 32'h0 || bus.op_count !== 16'h0) begin
            failures++;
            $display("FAIL reset_data got out=%h cnt=%0d want out=0 cnt=0", bus.rsp_out, bus.op_count);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int   n;
        exp_t e;
        set_req(0, 1'b1, 32'hFFFF_FFF8, 5'd2, 1'b0);
        #1;
        checks++;
        if (bus.req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_ready got=%b want=1", bus.req0_ready);
        end
        sb.push_back(model(1'b0, 32'hFFFF_FFF8, 5'd2, 1'b0));
        tick();
        set_req(0, 1'b0, '0, '0, 1'b0);
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_exec_valid got=%b want=0", bus.rsp_valid);
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL single_latency got rsp_valid=%b want=1", bus.rsp_valid);
            wait_valid(n);
        end
        e = sb.pop_front();
        checks++;
        if ({bus.rsp_id, bus.rsp_out, bus.rsp_of} !== e || e.out !== 32'hFFFF_FFFE) begin
            failures++;
            $display("FAIL single_rsp got id=%b out=%h of=%b want id=0 out=fffffffe of=0",
                     bus.rsp_id, bus.rsp_out, bus.rsp_of);
        end
        handshake();
        checks++;
        if (bus.op_count !== 16'd1 || bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_count got cnt=%0d valid=%b want cnt=1 valid=0", bus.op_count, bus.rsp_valid);
        end
    endtask

    task automatic test_left(input int k, input logic [31:0] a, input logic [4:0] b,
                             input logic [31:0] want_out, input logic want_of, input string name);
        int   w, n;
        exp_t e;
        issue(k, a, b, 1'b1, w);
        wait_valid(n);
        checks++;
        if (w != 0 || n != 1) begin
            failures++;
            $display("FAIL %s_timing got wait=%0d lat=%0d want wait=0 lat=1", name, w, n);
        end
        if (sb.size() == 0) e = '0; else e = sb.pop_front();
        checks++;
        if ({bus.rsp_id, bus.rsp_out, bus.rsp_of} !== {k[0], want_out, want_of} ||
            {bus.rsp_id, bus.rsp_out, bus.rsp_of} !== e) begin
            failures++;
            $display("FAIL %s_rsp got id=%b out=%h of=%b want id=%b out=%h of=%b",
                     name, bus.rsp_id, bus.rsp_out, bus.rsp_of, k[0], want_out, want_of);
        end
        handshake();
    endtask

    task automatic test_contention();
        int          g[$];
        int          t[$];
        int          cnt;
        exp_t        e;
        bit          take0, take1;
        logic [31:0] a0, a1;
        logic [4:0]  b0, b1;
        logic        s0, s1;
        cnt = 3;
        a0 = $urandom; b0 = 5'($urandom_range(0, 31)); s0 = 1'($urandom_range(0, 1));
        a1 = $urandom; b1 = 5'($urandom_range(0, 31)); s1 = 1'($urandom_range(0, 1));
        set_req(0, 1'b1, a0, b0, s0);
        set_req(1, 1'b1, a1, b1, s1);
        bus.rsp_ready = 1'b1;
        #1;
        for (int c = 0; c < 18; c++) begin
            take0 = bus.req0_ready;
            take1 = bus.req1_ready;
            if (take0) begin g.push_back(0); t.push_back(c); sb.push_back(model(1'b0, a0, b0, s0)); end
            if (take1) begin g.push_back(1); t.push_back(c); sb.push_back(model(1'b1, a1, b1, s1)); end
            if (bus.rsp_valid) begin
                if (sb.size() == 0) e = '0; else e = sb.pop_front();
                checks++;
                if ({bus.rsp_id, bus.rsp_out, bus.rsp_of} !== e) begin
                    failures++;
                    $display("FAIL contention_rsp cyc=%0d got id=%b out=%h of=%b want id=%b out=%h of=%b",
                             c, bus.rsp_id, bus.rsp_out, bus.rsp_of, e.id, e.out, e.of);
                end
                cnt++;
            end
            tick();
            checks++;
            if (bus.op_count !== 16'(cnt)) begin
                failures++;
                $display("FAIL contention_count cyc=%0d got=%0d want=%0d", c, bus.op_count, cnt);
            end
            if (take0) begin
                a0 = $urandom; b0 = 5'($urandom_range(0, 31)); s0 = 1'($urandom_range(0, 1));
                set_req(0, 1'b1, a0, b0, s0);
            end
            if (take1) begin
                a1 = $urandom; b1 = 5'($urandom_range(0, 31)); s1 = 1'($urandom_range(0, 1));
                set_req(1, 1'b1, a1, b1, s1);
            end
            #1;
        end
        set_req(0, 1'b0, '0, '0, 1'b0);
        set_req(1, 1'b0, '0, '0, 1'b0);
        bus.rsp_ready = 1'b0;
        checks++;
        if (g.size() != 6) begin
            failures++;
            $display("FAIL contention_grants got=%0d want=6", g.size());
        end
        for (int i = 0; i < g.size(); i++) begin
            checks++;
            if (g[i] != (i % 2) || t[i] != 3 * i) begin
                failures++;
                $display("FAIL contention_order idx=%0d got id=%0d cyc=%0d want id=%0d cyc=%0d",
                         i, g[i], t[i], i % 2, 3 * i);
            end
        end
    endtask

    task automatic test_backpressure();
        int   w, n;
        exp_t e;
        issue(0, 32'h0000_00F0, 5'd4, 1'b1, w);
        set_req(1, 1'b1, 32'h8000_0001, 5'd3, 1'b0);
        #1;
        checks++;
        if (bus.req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_exec_ready got=%b want=0", bus.req1_ready);
        end
        wait_valid(n);
        if (sb.size() == 0) e = '0; else e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.req1_ready !== 1'b0 ||
                {bus.rsp_id, bus.rsp_out, bus.rsp_of} !== e) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got valid=%b r1=%b out=%h want valid=1 r1=0 out=%h",
                         i, bus.rsp_valid, bus.req1_ready, bus.rsp_out, e.out);
            end
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        checks++;
        if (bus.req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_release_ready got=%b want=0", bus.req1_ready);
        end
        tick();
        bus.rsp_ready = 1'b0;
        #1;
        checks++;
        if (bus.req1_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_accept got r1=%b valid=%b want r1=1 valid=0", bus.req1_ready, bus.rsp_valid);
        end
        sb.push_back(model(1'b1, 32'h8000_0001, 5'd3, 1'b0));
        tick();
        set_req(1, 1'b0, '0, '0, 1'b0);
        wait_valid(n);
        if (sb.size() == 0) e = '0; else e = sb.pop_front();
        checks++;
        if (n != 1 || {bus.rsp_id, bus.rsp_out, bus.rsp_of} !== e) begin
            failures++;
            $display("FAIL bp_rsp got lat=%0d id=%b out=%h of=%b want lat=1 id=%b out=%h of=%b",
                     n, bus.rsp_id, bus.rsp_out, bus.rsp_of, e.id, e.out, e.of);
        end
        handshake();
        checks++;
        if (bus.op_count !== 16'd11) begin
            failures++;
            $display("FAIL bp_count got=%0d want=11", bus.op_count);
        end
    endtask

    task automatic test_reset_mid();
        int   w, n;
        bit   seen;
        exp_t e;
        issue(0, 32'hFE06_C203, 5'd31, 1'b0, w);
        rst = 1'b1;
        #1;
        if (sb.size() != 0) void'(sb.pop_back());
        checks++;
        if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_of} !== 5'b0 ||
            bus.rsp_out !== 32'h0 || bus.op_count !== 16'h0) begin
            failures++;
            $display("FAIL midrst_values got valid=%b id=%b out=%h of=%b cnt=%0d want all zero",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_out, bus.rsp_of, bus.op_count);
        end
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.rsp_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL midrst_no_rsp got rsp_valid=1 want=0");
        end
        issue(0, 32'hFE06_C203, 5'd31, 1'b0, w);
        wait_valid(n);
        if (sb.size() == 0) e = '0; else e = sb.pop_front();
        checks++;
        if (n != 1 || {bus.rsp_id, bus.rsp_out, bus.rsp_of} !== {1'b0, 32'hFFFF_FFFF, 1'b0} ||
            {bus.rsp_id, bus.rsp_out, bus.rsp_of} !== e) begin
            failures++;
            $display("FAIL midrst_reissue got lat=%0d id=%b out=%h of=%b want lat=1 id=0 out=ffffffff of=0",
                     n, bus.rsp_id, bus.rsp_out, bus.rsp_of);
        end
        handshake();
        checks++;
        if (bus.op_count !== 16'd1) begin
            failures++;
            $display("FAIL midrst_count got=%0d want=1", bus.op_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_left(0, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1'b0, "neg_limit");
`ifdef SHIFT_ARB_SAT_EN
        test_left(1, 32'h0000_0001, 5'd31, 32'h7FFF_FFFF, 1'b1, "overflow");
`else
        test_left(1, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b1, "overflow");
`endif
        test_contention();
        test_backpressure();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
